// File: rtl/mtsp_sf_rcp_nr_if.sv
// Operand/result handshake bundle for the SF-path reciprocal unit.
// The unit connects through the slave modport; the producer/consumer side uses master.
interface mtsp_sf_rcp_nr_if #(
   parameter int MW   = 23,
   parameter int TAGW = 4
);
   logic            in_valid;
   logic            in_ready;
   logic [MW-1:0]   in_m;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [MW:0]     out_rcp;
   logic [TAGW-1:0] out_tag;
   logic            busy;

   modport master (
      output in_valid, in_m, in_tag, out_ready,
      input  in_ready, out_valid, out_rcp, out_tag, busy
   );

   modport slave (
      input  in_valid, in_m, in_tag, out_ready,
      output in_ready, out_valid, out_rcp, out_tag, busy
   );
endinterface

// File: rtl/mtsp_sf_rcp_nr.sv
// Iterative reciprocal 1/(1.M) in Q1.MW: seed ROM followed by ITER Newton-Raphson steps.
// Internal datapath is unsigned Q2.(MW+GW); one operation in flight.
module mtsp_sf_rcp_nr #(
   parameter int MW   = 23,
   parameter int IW   = 8,
   parameter int SW   = 8,
   parameter int ITER = 2,
   parameter int TAGW = 4,
   parameter int GW   = 4
) (
   input logic                clk,
   input logic                rst,
   mtsp_sf_rcp_nr_if.slave    bus
);
   localparam int F = MW + GW;
   localparam int W = F + 2;

   typedef enum logic [2:0] {S_IDLE, S_SEED, S_MUL_A, S_MUL_B, S_DONE} state_t;

   state_t          state, state_nx;
   logic [MW-1:0]   m_q;
   logic [TAGW-1:0] tag_q;
   logic [1:0]      iter_q;
   logic [W-1:0]    x_q, t_q;
   logic [MW:0]     rcp_q;

   // round(2^SW / (1 + (i+0.5)/2^IW)) evaluated as exact integer division
   function automatic logic [SW:0] seed_entry(input int i);
      longint num, den;
      num = longint'(1) <<< (SW + IW + 2);
      den = (longint'(1) <<< (IW + 1)) + 2 * longint'(i) + 1;
      return (SW+1)'((num + den) / (2 * den));
   endfunction

   // NOTE: the seed ROM is constant logic built at elaboration, so it has no reset.
   logic [SW:0] rom [2**IW];
   for (genvar g = 0; g < 2**IW; g++) begin : g_rom
      assign rom[g] = seed_entry(g);
   end

   logic [W-1:0]   d_w, x_seed, two_minus_t, t_new, x_new;
   logic [2*W-1:0] prod_a, prod_b;
   logic [W:0]     x_rnd;
   logic [MW+2:0]  rnd;
   logic [MW:0]    rcp_final;

   always_comb begin
      d_w         = {2'b01, m_q, {GW{1'b0}}};
      x_seed      = {{(W-SW-1){1'b0}}, rom[m_q[MW-1 -: IW]]} << (F - SW);
      prod_a      = {{W{1'b0}}, d_w} * {{W{1'b0}}, x_q};
      t_new       = prod_a[F +: W];
      two_minus_t = (W'(1) << (F + 1)) - t_q;
      prod_b      = {{W{1'b0}}, x_q} * {{W{1'b0}}, two_minus_t};
      x_new       = prod_b[F +: W];
      x_rnd       = {1'b0, x_new} + (W+1)'(1 << (GW - 1));
      rnd         = x_rnd[W:GW];
      // Rounding can only reach 1.0 here because M==0 never enters the loop
      rcp_final   = (rnd[MW+2:MW] != 3'b000) ? {1'b0, {MW{1'b1}}} : rnd[MW:0];
   end

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.in_valid) state_nx = (bus.in_m == '0) ? S_DONE : S_SEED;
         S_SEED:  state_nx = S_MUL_A;
         S_MUL_A: state_nx = S_MUL_B;
         S_MUL_B: state_nx = (iter_q == 2'(ITER - 1)) ? S_DONE : S_MUL_A;
         S_DONE:  if (bus.out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         m_q    <= '0;
         tag_q  <= '0;
         iter_q <= '0;
         x_q    <= '0;
         t_q    <= '0;
         rcp_q  <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE: if (bus.in_valid) begin
               m_q    <= bus.in_m;
               tag_q  <= bus.in_tag;
               iter_q <= '0;
               if (bus.in_m == '0) rcp_q <= {1'b1, {MW{1'b0}}};
            end
            S_SEED:  x_q <= x_seed;
            S_MUL_A: t_q <= t_new;
            S_MUL_B: begin
               x_q    <= x_new;
               iter_q <= iter_q + 2'd1;
               if (state_nx == S_DONE) rcp_q <= rcp_final;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.busy      = (state != S_IDLE);
   assign bus.out_rcp   = rcp_q;
   assign bus.out_tag   = tag_q;

   // Product bits outside the kept window are discarded by design
   logic unused_bits;
   assign unused_bits = ^{prod_a[2*W-1:F+W], prod_a[F-1:0],
                          prod_b[2*W-1:F+W], prod_b[F-1:0], x_rnd[GW-1:0]};
endmodule

// File: tb/tb_mtsp_sf_rcp_nr.sv
// Bench for mtsp_sf_rcp_nr: directed handshake cases plus random operands on ITER=2 and ITER=1
// instances, checked against exact real-valued 1/d.
module tb_mtsp_sf_rcp_nr;
   localparam int MW   = 23;
   localparam int TAGW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mtsp_sf_rcp_nr_if #(.MW(MW), .TAGW(TAGW)) bus2 ();
   mtsp_sf_rcp_nr_if #(.MW(MW), .TAGW(TAGW)) bus1 ();

   mtsp_sf_rcp_nr #(.MW(MW), .IW(8), .SW(8), .ITER(2), .TAGW(TAGW), .GW(4)) u_dut2 (
      .clk(clk), .rst(rst), .bus(bus2));
   mtsp_sf_rcp_nr #(.MW(MW), .IW(8), .SW(8), .ITER(1), .TAGW(TAGW), .GW(4)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   // Stimulus is steered to one instance at a time; the other sees idle inputs
   int              sel_iter = 2;
   logic            v_valid  = 1'b0;
   logic            v_oready = 1'b0;
   logic [MW-1:0]   v_m      = '0;
   logic [TAGW-1:0] v_tag    = '0;

   assign bus2.in_valid  = v_valid  && (sel_iter == 2);
   assign bus1.in_valid  = v_valid  && (sel_iter == 1);
   assign bus2.out_ready = v_oready && (sel_iter == 2);
   assign bus1.out_ready = v_oready && (sel_iter == 1);
   assign bus2.in_m      = v_m;
   assign bus1.in_m      = v_m;
   assign bus2.in_tag    = v_tag;
   assign bus1.in_tag    = v_tag;

   logic            o_valid, o_rdy, o_busy;
   logic [MW:0]     o_rcp;
   logic [TAGW-1:0] o_tag;
   assign o_valid = (sel_iter == 2) ? bus2.out_valid : bus1.out_valid;
   assign o_rdy   = (sel_iter == 2) ? bus2.in_ready  : bus1.in_ready;
   assign o_busy  = (sel_iter == 2) ? bus2.busy      : bus1.busy;
   assign o_rcp   = (sel_iter == 2) ? bus2.out_rcp   : bus1.out_rcp;
   assign o_tag   = (sel_iter == 2) ? bus2.out_tag   : bus1.out_tag;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: accept, wait for the result, optional stall, handoff
   task automatic do_op(input logic [MW-1:0] m, input logic [TAGW-1:0] tag,
                        input int stall, input bit poke);
      int              lat;
      bit              side_ok, stable;
      real             exact, err, tol;
      logic [MW:0]     rcp0;
      logic [TAGW-1:0] tag0;
      v_m = m; v_tag = tag; v_valid = 1'b1;
      chk("accept_ready", o_rdy, 1);
      cyc();
      v_valid = 1'b0;
      lat = 1; side_ok = 1'b1;
      while (!o_valid && lat < 40) begin
         if (o_rdy || !o_busy) side_ok = 1'b0;
         cyc();
         lat++;
      end
      chk("out_valid_seen", o_valid, 1);
      chk($sformatf("latency m=%h", m), lat, (m == '0) ? 1 : 2 + 2 * sel_iter);
      chk("busy_not_ready", side_ok && !o_rdy && o_busy, 1);
      chk("out_tag", o_tag, tag);
      if (m == '0) begin
         chk("rcp_one", o_rcp, {1'b1, {MW{1'b0}}});
      end else begin
         exact = (2.0 ** MW) / (1.0 + real'(m) / (2.0 ** MW));
         err   = real'(o_rcp) - exact;
         if (err < 0.0) err = -err;
         tol   = (sel_iter >= 2) ? 2.0 : 2.0 ** (MW - 16);
         chk($sformatf("rcp_error m=%h rcp=%h iter=%0d", m, o_rcp, sel_iter), err <= tol, 1);
         chk($sformatf("rcp_range rcp=%h", o_rcp),
             (o_rcp >= (1 << (MW - 1))) && (o_rcp < (1 << MW)), 1);
      end
      rcp0 = o_rcp; tag0 = o_tag; stable = 1'b1;
      for (int s = 0; s < stall; s++) begin
         if (poke) begin
            v_valid = s[0];
            v_m     = MW'($urandom);
            v_tag   = ~tag;
         end
         cyc();
         if (!o_valid || o_rcp !== rcp0 || o_tag !== tag0 || o_rdy) stable = 1'b0;
      end
      v_valid = 1'b0;
      chk("hold_stable", stable, 1);
      v_oready = 1'b1;
      cyc();
      v_oready = 1'b0;
      chk("handoff_valid", o_valid, 0);
      chk("handoff_ready", o_rdy, 1);
      chk("handoff_busy", o_busy, 0);
   endtask

   initial begin
      bit quiet;
      logic [MW-1:0] rm;

      // Reset state
      repeat (3) cyc();
      rst = 1'b0;
      chk("rst_valid", o_valid, 0);
      chk("rst_rcp", o_rcp, 0);
      chk("rst_tag", o_tag, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_rdy, 1);

      // M=0 yields exact 1.0 one cycle after accept
      do_op(23'h000000, 4'd5, 3, 1'b0);
      // d = 1.5
      do_op(23'h400000, 4'd6, 0, 1'b0);
      // Extremes of the mantissa range
      do_op(23'h7FFFFF, 4'd7, 0, 1'b0);
      do_op(23'h000001, 4'd8, 1, 1'b0);
      // Long output stall with ignored input pulses, then immediate next accept
      do_op(23'h2AAAAA, 4'd9, 10, 1'b1);
      do_op(23'h123456, 4'd10, 0, 1'b0);

      // Reset while the iteration loop is running
      v_m = 23'h345678; v_tag = 4'd11; v_valid = 1'b1;
      cyc();
      v_valid = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("midrst_valid", o_valid, 0);
      chk("midrst_busy", o_busy, 0);
      chk("midrst_ready", o_rdy, 1);
      chk("midrst_tag", o_tag, 0);
      chk("midrst_rcp", o_rcp, 0);
      quiet = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cyc();
         if (o_valid || o_busy) quiet = 1'b0;
      end
      chk("midrst_no_stale", quiet, 1);

      // Random operands with random output stalls on both iteration counts
      for (int it = 2; it >= 1; it--) begin
         sel_iter = it;
         cyc();
         for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 19))
               0:       rm = '0;
               1:       rm = {MW{1'b1}};
               2:       rm = MW'($urandom_range(1, 255));
               default: rm = MW'($urandom);
            endcase
            do_op(rm, TAGW'(k), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
